// File: rtl/e_ppn_mod_fix.sv
// Limb-serial modular correction: folds a raw add/sub result (plus carry/borrow)
// into [0, p) with at most one conditional subtraction or addition of p.
module e_ppn_mod_fix #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             c_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] data_o,
  output logic             corr_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {IDLE, CAL, SEL} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] t_r;
  logic             op_r;
  logic             c_r;
  logic [LIMB-1:0]  d_limb;
  logic [LIMB-1:0]  p_limb;
  logic [LIMB:0]    limb_sum;
  logic             last_limb;
  logic             apply;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i)   state_n = CAL;
      CAL:     if (last_limb) state_n = SEL;
      SEL:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Add path computes d - p (d + ~p + 1); subtract path computes d + p.
  always_comb begin
    d_limb    = d_r[idx*LIMB +: LIMB];
    p_limb    = op_r ? p_i[idx*LIMB +: LIMB] : ~p_i[idx*LIMB +: LIMB];
    limb_sum  = {1'b0, d_limb} + {1'b0, p_limb} + {{LIMB{1'b0}}, carry};
    last_limb = (idx == IW'(NLIMB - 1));
    apply     = op_r ? c_r : (c_r | carry);
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      d_r    <= '0;
      t_r    <= '0;
      op_r   <= 1'b0;
      c_r    <= 1'b0;
      data_o <= '0;
      corr_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            d_r   <= data_i;
            op_r  <= op_i;
            c_r   <= c_i;
            idx   <= '0;
            carry <= ~op_i;
          end
        end
        CAL: begin
          t_r[idx*LIMB +: LIMB] <= limb_sum[LIMB-1:0];
          carry                 <= limb_sum[LIMB];
          idx                   <= idx + 1'b1;
        end
        SEL: begin
          data_o <= apply ? t_r : d_r;
          corr_o <= apply;
          done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_ppn_mod_fix.sv
// Directed bench for e_ppn_mod_fix using secp256k1 p and hand-computed results.
module tb_e_ppn_mod_fix;

  localparam int WIDTH = 256;
  localparam int LIMB  = 64;
  localparam logic [WIDTH-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start_i;
  logic             op_i;
  logic [WIDTH-1:0] data_i;
  logic             c_i;
  logic [WIDTH-1:0] p_i;
  logic [WIDTH-1:0] data_o;
  logic             corr_o;
  logic             done_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  e_ppn_mod_fix #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (start_i),
    .op_i    (op_i),
    .data_i  (data_i),
    .c_i     (c_i),
    .p_i     (p_i),
    .data_o  (data_o),
    .corr_o  (corr_o),
    .done_o  (done_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns 1ns after the edge that samples it.
  task automatic applyStimulus(input logic op, input logic c, input logic [WIDTH-1:0] data);
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    c_i     = c;
    data_i  = data;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic waitDone(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = busy_o ? 1 : 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy_o) busy_cnt++;
      if (done_o) break;
    end
  endtask

  task automatic runCase(input string tag, input logic op, input logic c,
                         input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] exp_data,
                         input logic exp_corr);
    int edges, busy_cnt;
    applyStimulus(op, c, data);
    waitDone(edges, busy_cnt);
    checkOutput({tag, "_latency"}, WIDTH'(edges), WIDTH'(5));
    checkOutput({tag, "_busy_cycles"}, WIDTH'(busy_cnt), WIDTH'(5));
    checkOutput({tag, "_data"}, data_o, exp_data);
    checkOutput({tag, "_corr"}, WIDTH'(corr_o), WIDTH'(exp_corr));
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_one_cycle"}, WIDTH'(done_o), WIDTH'(0));
  endtask

  initial begin
    int dones;
    reset_n = 1'b0;
    start_i = 1'b0;
    op_i    = 1'b0;
    c_i     = 1'b0;
    data_i  = '0;
    p_i     = P;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data", data_o, '0);
    checkOutput("reset_corr", WIDTH'(corr_o), WIDTH'(0));
    checkOutput("reset_done", WIDTH'(done_o), WIDTH'(0));
    checkOutput("reset_busy", WIDTH'(busy_o), WIDTH'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed add/sub vectors");
    runCase("add_5", 1'b0, 1'b0, WIDTH'(5), WIDTH'(5), 1'b0);
    runCase("add_p_plus3", 1'b0, 1'b0, P + WIDTH'(3), WIDTH'(3), 1'b1);
    runCase("add_p", 1'b0, 1'b0, P, '0, 1'b1);
    runCase("add_p_minus1", 1'b0, 1'b0, P - WIDTH'(1), P - WIDTH'(1), 1'b0);
    runCase("add_ovf", 1'b0, 1'b1, WIDTH'(12'h3D0), WIDTH'(36'h1_000007A1), 1'b1);
    runCase("sub_neg", 1'b1, 1'b1, {WIDTH{1'b1}}, P - WIDTH'(1), 1'b1);
    runCase("sub_7", 1'b1, 1'b0, WIDTH'(7), WIDTH'(7), 1'b0);
    runCase("sub_zero", 1'b1, 1'b0, '0, '0, 1'b0);

    $display("[TB] start while busy");
    applyStimulus(1'b0, 1'b0, WIDTH'(11));
    @(posedge clk);
    #1;
    start_i = 1'b1;
    op_i    = 1'b1;
    c_i     = 1'b1;
    data_i  = WIDTH'(99);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    data_i  = '0;
    dones   = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    checkOutput("busy_start_dones", WIDTH'(dones), WIDTH'(1));
    checkOutput("busy_start_data", data_o, WIDTH'(11));
    checkOutput("busy_start_corr", WIDTH'(corr_o), WIDTH'(0));

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b1, WIDTH'(12'h3D0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput("midreset_data", data_o, '0);
    checkOutput("midreset_corr", WIDTH'(corr_o), WIDTH'(0));
    checkOutput("midreset_done", WIDTH'(done_o), WIDTH'(0));
    checkOutput("midreset_busy", WIDTH'(busy_o), WIDTH'(0));
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    checkOutput("midreset_no_done", WIDTH'(dones), WIDTH'(0));
    runCase("after_reset", 1'b0, 1'b0, P + WIDTH'(3), WIDTH'(3), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_ppn_mod_fix.md
# e_ppn_mod_fix

Limb-serial modular correction stage that sits directly downstream of the 256-bit KSA add/sub wrapper in the ECDSA datapath. It takes the raw non-modular sum or difference (result plus carry/borrow flag) and folds it into [0, p) with at most one conditional subtraction or addition of the field modulus. Operands are processed LIMB bits per cycle, and completion is reported with a one-cycle done pulse.

## Interface
- WIDTH, 256, operand and modulus width; must be an integer multiple of LIMB.
- LIMB, 64, bits processed per CAL cycle; NLIMB = WIDTH/LIMB.
- clk  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start_i  in  1  one-cycle request, connected to the add/sub done pulse; ignored unless state is IDLE.
- op_i  in  1  0 means the upstream operation was an add, 1 means it was a subtract.
- data_i  in  WIDTH  raw upstream result (mod 2^WIDTH).
- c_i  in  1  upstream flag: on add, 1 = overflow past 2^WIDTH; on subtract, 1 = result negative.
- p_i  in  WIDTH  modulus; must stay stable from start_i until done_o.
- data_o  out  WIDTH  corrected result in [0, p).
- corr_o  out  1  1 when the modulus was applied.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in CAL and SEL.

## Operation
- Precondition: the upstream operands lie in [0, p), so the true result lies in (-p, 2p) and one correction always suffices.
- FSM states: IDLE, CAL, SEL.
  - IDLE: when start_i = 1, latch data_i into d_r, and latch op_i and c_i. Clear the limb index, and clear the carry register to op_i ? 0 : 1. Go to CAL.
  - CAL: for each limb k = index, compute t[k] = d_r[k] + (op ? p[k] : ~p[k]) + carry. Store t[k] and update carry with the limb carry-out. Increment the index. After limb NLIMB-1, go to SEL.
  - SEL: decide whether to apply the correction.
    - Add: apply = c_i OR final carry. A final carry of 1 means d_r >= p, i.e. no borrow.
    - Subtract: apply = c_i.
    - Write data_o = apply ? t : d_r and corr_o = apply. Pulse done_o. Go to IDLE.
- All arithmetic is mod 2^WIDTH. The final carry is used only for the add decision.
- data_o and corr_o hold their values until the next SEL.
- start_i while busy_o = 1 is dropped. It is neither queued nor allowed to corrupt the latched operands.
- Boundary conditions:
  - add with data_i = p exactly and c_i = 0: output 0, corr 1.
  - add with data_i = p-1: output p-1, corr 0.
  - subtract with data_i = 0 and c_i = 0: output 0.

## Timing
- Reset (reset_n low at an edge) forces state IDLE, index 0, carry 0, and data_o = 0, corr_o = 0, done_o = 0, busy_o = 0. This holds mid-operation too: the in-flight request is abandoned and no done_o follows.
- Let start_i be sampled at edge E0.
  - busy_o is high after edges E0 through E0+NLIMB.
  - CAL occupies edges E0+1 through E0+NLIMB.
  - data_o, corr_o and the done_o pulse become valid after edge E0+NLIMB+1, which is 5 edges for the default parameters.
- done_o is high for exactly one cycle.
- A new start_i is accepted on the edge following done_o, because state is IDLE in that cycle. Back-to-back throughput is one result per NLIMB+2 cycles.
- Inputs sampled in IDLE: data_i, op_i, c_i. p_i is read live during CAL.

## Test plan
All scenarios use P = secp256k1 p = FFFFFFFF…FFFFFFFE_FFFFFC2F, with WIDTH=256 and LIMB=64.
- Add, data_i=5, c_i=0 -> data_o=5, corr_o=0, done_o exactly 5 edges after start, busy_o high for 5 cycles.
- Add, c_i=0, two cases:
  - data_i=P+3 -> data_o=3, corr_o=1.
  - data_i=P -> data_o=0, corr_o=1.
  - Then data_i=P-1 -> data_o=P-1, corr_o=0.
- Add, data_i=0x3D0, c_i=1 -> data_o=0x1_000007A1, corr_o=1. This covers carry propagation across all limbs.
- Subtract, c_i=1:
  - data_i=2^256-1 -> data_o=P-1 (…FFFFFC2E), corr_o=1.
  - Then subtract with data_i=7, c_i=0 -> data_o=7, corr_o=0.
- Control cases:
  - A second start_i with different data, pulsed 2 cycles after the first -> ignored; data_o is the first result, and only one done_o pulse occurs.
  - reset_n low at the 3rd CAL cycle -> all outputs 0 on the next edge, no done_o; the next request completes normally.
